// File: rtl/sevenseg_scan_encoder_pkg.sv
// Shared definitions for the seven-segment scan encoder: segment patterns,
// FSM states and the select-line validity check.
package sevenseg_scan_encoder_pkg;

    // Widest select bus supported; narrower buses are padded with inactive (high) bits.
    localparam int unsigned MAX_DIGITS = 8;

    // Active-low segment patterns {g,f,e,d,c,b,a} for each hex value.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    typedef enum logic [1:0] {
        WAIT_SEL = 2'd0,
        SETTLE   = 2'd1,
        HELD     = 2'd2
    } state_t;

    // True when exactly one select line is driven low.
    function automatic logic one_hot_low(input logic [MAX_DIGITS-1:0] an);
        int unsigned zeros;
        zeros = 0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (!an[i]) zeros++;
        end
        return (zeros == 1);
    endfunction

endpackage

// File: rtl/sevenseg_scan_encoder_if.sv
// Display-side inputs and frame-side handshake of the scan encoder.
// The encoder is the frame source (master); the consumer/stimulus side is the slave.
interface sevenseg_scan_encoder_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [NUM_DIGITS-1:0]   an_in;
    logic [6:0]              seg_in;
    logic [4*NUM_DIGITS-1:0] frame_hex;
    logic [NUM_DIGITS-1:0]   frame_err;
    logic                    frame_valid;
    logic                    frame_ready;
    logic                    overrun;

    modport master (
        input  an_in, seg_in, frame_ready,
        output frame_hex, frame_err, frame_valid, overrun
    );

    modport slave (
        output an_in, seg_in, frame_ready,
        input  frame_hex, frame_err, frame_valid, overrun
    );
endinterface

// File: rtl/sevenseg_pattern_encoder.sv
// Combinational decode of an active-low segment pattern back to its hex value.
module sevenseg_pattern_encoder
    import sevenseg_scan_encoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       err
);

    // Table lookup; any pattern outside the table is flagged as an error.
    always_comb begin
        hex = '0;
        err = 1'b0;
        case (seg)
            SEG_0: hex = 4'h0;
            SEG_1: hex = 4'h1;
            SEG_2: hex = 4'h2;
            SEG_3: hex = 4'h3;
            SEG_4: hex = 4'h4;
            SEG_5: hex = 4'h5;
            SEG_6: hex = 4'h6;
            SEG_7: hex = 4'h7;
            SEG_8: hex = 4'h8;
            SEG_9: hex = 4'h9;
            SEG_A: hex = 4'hA;
            SEG_B: hex = 4'hB;
            SEG_C: hex = 4'hC;
            SEG_D: hex = 4'hD;
            SEG_E: hex = 4'hE;
            SEG_F: hex = 4'hF;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_encoder.sv
// Seven-segment scan receiver: waits for each selected digit to settle, decodes it
// into a working frame and hands complete frames out over valid/ready.
module sevenseg_scan_encoder
    import sevenseg_scan_encoder_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned CNT_W         = 4
)(
    input  logic clk,
    input  logic reset,
    sevenseg_scan_encoder_if.master bus
);

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_inc;
    logic [NUM_DIGITS-1:0]   held_an;
    logic [6:0]              held_seg;
    logic [NUM_DIGITS-1:0]   mask;
    logic [NUM_DIGITS-1:0]   mask_next;
    logic [NUM_DIGITS-1:0]   work_err;
    logic [4*NUM_DIGITS-1:0] work_hex;
    logic [MAX_DIGITS-1:0]   an_pad;
    logic                    sel_ok;
    logic                    same;
    logic                    restart;
    logic                    capture;
    logic                    mask_full;
    logic [3:0]              enc_hex;
    logic                    enc_err;

    sevenseg_pattern_encoder u_enc (
        .seg (bus.seg_in),
        .hex (enc_hex),
        .err (enc_err)
    );

    // WAIT_SEL and a change seen in SETTLE/HELD share one restart path; capture fires
    // either on a restart (only when one cycle is enough) or when the count reaches the target.
    always_comb begin
        an_pad                 = '1;
        an_pad[NUM_DIGITS-1:0] = bus.an_in;
        sel_ok    = one_hot_low(an_pad);
        same      = (bus.an_in == held_an) && (bus.seg_in == held_seg);
        cnt_inc   = cnt + CNT_ONE;
        restart   = (state == WAIT_SEL) || !same;
        capture   = 1'b0;
        if (restart) begin
            capture = sel_ok && (STABLE_CYCLES == 1);
        end else if (state == SETTLE) begin
            capture = (cnt_inc == STABLE_CNT);
        end
        mask_full = &mask;
        mask_next = (mask_full ? '0 : mask) | (~bus.an_in & {NUM_DIGITS{capture}});
    end

    // Stability FSM: track the current {an_in,seg_in} and count identical cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= WAIT_SEL;
            cnt      <= '0;
            held_an  <= '0;
            held_seg <= '0;
        end else if (restart) begin
            if (sel_ok) begin
                cnt      <= CNT_ONE;
                held_an  <= bus.an_in;
                held_seg <= bus.seg_in;
                state    <= capture ? HELD : SETTLE;
            end else begin
                cnt   <= '0;
                state <= WAIT_SEL;
            end
        end else if (state == SETTLE) begin
            cnt <= cnt_inc;
            if (capture) state <= HELD;
        end
    end

    // Working frame: decode captured digits, track which digits have been seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask     <= '0;
            work_hex <= '0;
            work_err <= '0;
        end else begin
            mask <= mask_next;
            for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                if (capture && !bus.an_in[d]) begin
                    if (!enc_err) work_hex[4*d +: 4] <= enc_hex;
                    work_err[d] <= enc_err;
                end
            end
        end
    end

    // Frame output: load a completed frame unless the previous one is still unaccepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.frame_hex   <= '0;
            bus.frame_err   <= '0;
            bus.frame_valid <= 1'b0;
            bus.overrun     <= 1'b0;
        end else if (mask_full) begin
            if (bus.frame_valid && !bus.frame_ready) begin
                bus.overrun <= 1'b1;
            end else begin
                bus.frame_hex   <= work_hex;
                bus.frame_err   <= work_err;
                bus.frame_valid <= 1'b1;
            end
        end else if (bus.frame_valid && bus.frame_ready) begin
            bus.frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_encoder.sv
// Self-checking bench for sevenseg_scan_encoder: directed scans plus random scanning,
// compared every cycle against a run-length reference model of the display receiver.
module tb_sevenseg_scan_encoder;

    localparam int unsigned ND = 4;
    localparam int unsigned SC = 8;

    logic clk;
    logic reset;

    sevenseg_scan_encoder_if #(.NUM_DIGITS(ND)) bus ();

    sevenseg_scan_encoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC),
        .CNT_W         (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [6:0] seg_tab [16];

    // reference model state
    int          run;
    logic        prev_ok;
    logic [10:0] prev;
    logic [3:0]  m_hex [ND];
    logic        m_err [ND];
    logic [ND-1:0] m_mask;
    logic        pend;
    logic [4*ND-1:0] p_hex;
    logic [ND-1:0]   p_err;
    logic        m_valid;
    logic [4*ND-1:0] m_ohex;
    logic [ND-1:0]   m_oerr;
    logic        m_over;

    // observation helpers
    int unsigned     pulses;
    logic            last_valid_obs;
    logic [4*ND-1:0] last_hex;
    logic [ND-1:0]   last_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] decode(input logic [6:0] seg);
        for (int i = 0; i < 16; i++) begin
            if (seg_tab[i] == seg) return {1'b0, 4'(i)};
        end
        return 5'b10000;
    endfunction

    task automatic model_reset();
        run = 0; prev_ok = 1'b0; prev = '0;
        for (int d = 0; d < ND; d++) begin m_hex[d] = '0; m_err[d] = 1'b0; end
        m_mask = '0; pend = 1'b0; p_hex = '0; p_err = '0;
        m_valid = 1'b0; m_ohex = '0; m_oerr = '0; m_over = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the inputs present at the edge.
    task automatic model_edge();
        logic [10:0] s;
        logic [4:0]  dec;
        int          d;
        if (pend) begin
            if (m_valid && !bus.frame_ready) m_over = 1'b1;
            else begin m_ohex = p_hex; m_oerr = p_err; m_valid = 1'b1; end
            pend = 1'b0;
        end else if (m_valid && bus.frame_ready) begin
            m_valid = 1'b0;
        end
        s = {bus.an_in, bus.seg_in};
        if (prev_ok && s == prev) run++; else run = 1;
        prev = s; prev_ok = 1'b1;
        if ($countones(~bus.an_in) == 1 && run == SC) begin
            d = 0;
            for (int i = 0; i < ND; i++) if (!bus.an_in[i]) d = i;
            dec = decode(bus.seg_in);
            if (!dec[4]) m_hex[d] = dec[3:0];
            m_err[d] = dec[4];
            m_mask[d] = 1'b1;
            if (&m_mask) begin
                for (int i = 0; i < ND; i++) begin p_hex[4*i +: 4] = m_hex[i]; p_err[i] = m_err[i]; end
                pend = 1'b1;
                m_mask = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("valid", {31'd0, bus.frame_valid}, {31'd0, m_valid});
        check("overrun", {31'd0, bus.overrun}, {31'd0, m_over});
        if (m_valid) begin
            check("frame_hex", {16'd0, bus.frame_hex}, {16'd0, m_ohex});
            check("frame_err", {28'd0, bus.frame_err}, {28'd0, m_oerr});
        end
        if (bus.frame_valid && !last_valid_obs) pulses++;
        if (bus.frame_valid) begin last_hex = bus.frame_hex; last_err = bus.frame_err; end
        last_valid_obs = bus.frame_valid;
    endtask

    task automatic show(input int d, input logic [6:0] seg, input int cycles);
        bus.an_in  = ~(4'(1) << d);
        bus.seg_in = seg;
        repeat (cycles) tick();
    endtask

    task automatic idle(input int cycles);
        bus.an_in  = '1;
        bus.seg_in = '1;
        repeat (cycles) tick();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_hex"},     {16'd0, bus.frame_hex},   32'd0);
        check({tag, "_err"},     {28'd0, bus.frame_err},   32'd0);
        check({tag, "_valid"},   {31'd0, bus.frame_valid}, 32'd0);
        check({tag, "_overrun"}, {31'd0, bus.overrun},     32'd0);
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010; seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

        pulses = 0; last_valid_obs = 1'b0; last_hex = '0; last_err = '0;
        bus.an_in = '1; bus.seg_in = '1; bus.frame_ready = 1'b1;
        reset = 1'b1;
        model_reset();
        #12;
        check_zero_outputs("reset");
        reset = 1'b0;
        #5;

        // 1: clean scan, consumer always ready -> one pulse carrying 4321
        pulses = 0;
        for (int d = 0; d < 4; d++) show(d, seg_tab[d+1], 10);
        idle(4);
        check("t1_pulses", pulses, 32'd1);
        check("t1_hex", {16'd0, last_hex}, 32'h4321);
        check("t1_err", {28'd0, last_err}, 32'd0);

        // 2: short window on digit 1 with a different pattern is ignored
        pulses = 0;
        show(0, seg_tab[1], 10);
        show(1, seg_tab[8], 5);
        show(1, seg_tab[2], 10);
        show(2, seg_tab[3], 10);
        show(3, seg_tab[4], 10);
        idle(4);
        check("t2_pulses", pulses, 32'd1);
        check("t2_hex", {16'd0, last_hex}, 32'h4321);

        // 3: blank digit 2 is flagged, its hex keeps the previous value
        bus.frame_ready = 1'b0;
        show(0, seg_tab[1], 10);
        show(1, seg_tab[2], 10);
        show(2, 7'b1111111, 10);
        show(3, seg_tab[4], 10);
        idle(3);
        check("t3_valid", {31'd0, bus.frame_valid}, 32'd1);
        check("t3_hex", {16'd0, bus.frame_hex}, 32'h4321);
        check("t3_err", {28'd0, bus.frame_err}, 32'h4);
        bus.frame_ready = 1'b1;
        tick();
        check("t3_accept", {31'd0, bus.frame_valid}, 32'd0);

        // 4: invalid selects never capture
        pulses = 0;
        bus.an_in = 4'b0000; bus.seg_in = seg_tab[5];
        repeat (20) tick();
        bus.an_in = 4'b1111;
        repeat (20) tick();
        check("t4_pulses", pulses, 32'd0);
        check("t4_valid", {31'd0, bus.frame_valid}, 32'd0);

        // 5: two frames with no consumer -> first held, second dropped, overrun set
        bus.frame_ready = 1'b0;
        for (int d = 0; d < 4; d++) show(d, seg_tab[d+5], 10);
        for (int d = 0; d < 4; d++) show(d, seg_tab[d+9], 10);
        idle(3);
        check("t5_valid", {31'd0, bus.frame_valid}, 32'd1);
        check("t5_hex", {16'd0, bus.frame_hex}, 32'h8765);
        check("t5_overrun", {31'd0, bus.overrun}, 32'd1);
        bus.frame_ready = 1'b1;
        tick();
        check("t5_accept", {31'd0, bus.frame_valid}, 32'd0);
        check("t5_sticky", {31'd0, bus.overrun}, 32'd1);

        // 6: reset mid-frame discards partial work
        bus.frame_ready = 1'b0;
        show(0, seg_tab[1], 10);
        show(1, seg_tab[2], 4);
        reset = 1'b1;
        model_reset();
        #1;
        check_zero_outputs("midreset");
        #20;
        reset = 1'b0;
        for (int d = 0; d < 4; d++) show(d, seg_tab[d+12], 10);
        idle(3);
        check("t6_valid", {31'd0, bus.frame_valid}, 32'd1);
        check("t6_hex", {16'd0, bus.frame_hex}, 32'hFEDC);
        check("t6_err", {28'd0, bus.frame_err}, 32'd0);
        check("t6_overrun", {31'd0, bus.overrun}, 32'd0);

        // random scanning with random consumer stalls
        for (int it = 0; it < 300; it++) begin
            int unsigned hold;
            hold = $urandom_range(1, 12);
            if ($urandom_range(0, 7) == 0) bus.an_in = 4'($urandom);
            else bus.an_in = ~(4'(1) << $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) bus.seg_in = 7'($urandom);
            else bus.seg_in = seg_tab[$urandom_range(0, 15)];
            for (int c = 0; c < int'(hold); c++) begin
                bus.frame_ready = ($urandom_range(0, 2) != 0);
                tick();
            end
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
